// File: rtl/vga_dither_out.sv
// Video output stage that reduces IN_BITS-per-channel RGB to OUT_BITS per channel.
// It can truncate, apply 2x2 or 4x4 ordered (Bayer) dithering, or apply 4x4
// dithering whose columns rotate once per frame. Pixel and line phase come from
// the sync leading edges. The syncs are delayed so they stay aligned with the colour.
module vga_dither_out #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 3,
  parameter int SYNC_POL = 0
) (
  input  logic                clk_vga,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic [1:0]          mode,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  input  logic                hs_in,
  input  logic                vs_in,
  output logic [OUT_BITS-1:0] r_out,
  output logic [OUT_BITS-1:0] g_out,
  output logic [OUT_BITS-1:0] b_out,
  output logic                hs_out,
  output logic                vs_out
);

  localparam int D = IN_BITS - OUT_BITS;
  // Threshold scaling from the 4-bit matrix value down or up to D bits.
  localparam int SHR = (D <= 4) ? (4 - D) : 0;
  localparam int SHL = (D > 4) ? (D - 4) : 0;
  localparam logic ACT = (SYNC_POL != 0);
  localparam logic [IN_BITS:0] OUT_MAX = (IN_BITS+1)'((1 << OUT_BITS) - 1);

  // Stage 1 registers: input sample plus the phase that belongs to it.
  logic [IN_BITS-1:0] r_p0, g_p0, b_p0;
  logic               hs_p0, vs_p0;
  logic [1:0]         xph, yph, frm, mode_q;

  logic               hs_lead, vs_lead;
  logic [1:0]         xcol;
  logic [3:0]         m;
  logic [D-1:0]       t;

  // 4x4 Bayer matrix; rows are indexed by y and columns by x.
  function automatic logic [3:0] bayer4(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] v;
    case ({y, x})
      4'h0: v = 4'd0;  4'h1: v = 4'd8;  4'h2: v = 4'd2;  4'h3: v = 4'd10;
      4'h4: v = 4'd12; 4'h5: v = 4'd4;  4'h6: v = 4'd14; 4'h7: v = 4'd6;
      4'h8: v = 4'd3;  4'h9: v = 4'd11; 4'hA: v = 4'd1;  4'hB: v = 4'd9;
      4'hC: v = 4'd15; 4'hD: v = 4'd7;  4'hE: v = 4'd13; default: v = 4'd5;
    endcase
    return v;
  endfunction

  // 2x2 Bayer matrix (0 2 / 3 1).
  function automatic logic [1:0] bayer2(input logic x, input logic y);
    logic [1:0] v;
    case ({y, x})
      2'b00: v = 2'd0;
      2'b01: v = 2'd2;
      2'b10: v = 2'd3;
      default: v = 2'd1;
    endcase
    return v;
  endfunction

  // Scale the 4-bit matrix value into a D-bit threshold.
  function automatic logic [D-1:0] scale_thr(input logic [3:0] mv);
    logic [D+3:0] ext;
    ext = (D+4)'(mv);
    ext = (ext >> SHR) << SHL;
    return ext[D-1:0];
  endfunction

  // Add the threshold, drop the low D bits, and clamp to the output range.
  function automatic logic [OUT_BITS-1:0] dither_sat(input logic [IN_BITS-1:0] c,
                                                     input logic [D-1:0] th);
    logic [IN_BITS:0] s;
    logic [IN_BITS:0] q;
    s = (IN_BITS+1)'(c) + (IN_BITS+1)'(th);
    q = s >> D;
    if (q > OUT_MAX) return OUT_MAX[OUT_BITS-1:0];
    return q[OUT_BITS-1:0];
  endfunction

  assign hs_lead = (hs_in == ACT) && (hs_p0 != ACT);
  assign vs_lead = (vs_in == ACT) && (vs_p0 != ACT);
  assign xcol    = xph + frm;

  // Stage 1 control: sync history, phase counters and the frame-latched mode.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      hs_p0  <= ~ACT;
      vs_p0  <= ~ACT;
      xph    <= 2'd0;
      yph    <= 2'd0;
      frm    <= 2'd0;
      mode_q <= 2'd0;
    end else if (pix_ce) begin
      hs_p0 <= hs_in;
      vs_p0 <= vs_in;
      xph   <= hs_lead ? 2'd0 : xph + 2'd1;
      if (vs_lead)      yph <= 2'd0;
      else if (hs_lead) yph <= yph + 2'd1;
      if (vs_lead) begin
        frm    <= frm + 2'd1;
        mode_q <= mode;
      end
    end
  end

  // Stage 1 data: colour sample.
  always_ff @(posedge clk_vga) begin
    if (pix_ce) begin
      r_p0 <= r_in;
      g_p0 <= g_in;
      b_p0 <= b_in;
    end
  end

  // Threshold lookup for the pixel held in stage 1.
  always_comb begin
    m = 4'd0;
    case (mode_q)
      2'd1:    m = {bayer2(xph[0], yph[0]), 2'b00};
      2'd2:    m = bayer4(xph, yph);
      2'd3:    m = bayer4(xcol, yph);
      default: m = 4'd0;
    endcase
    t = (mode_q == 2'd0) ? '0 : scale_thr(m);
  end

  // ---- stage 1 -> stage 2 boundary ----
  // Stage 2: dithered, saturated colour and delayed syncs.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_out  <= '0;
      g_out  <= '0;
      b_out  <= '0;
      hs_out <= ~ACT;
      vs_out <= ~ACT;
    end else if (pix_ce) begin
      r_out  <= dither_sat(r_p0, t);
      g_out  <= dither_sat(g_p0, t);
      b_out  <= dither_sat(b_p0, t);
      hs_out <= hs_p0;
      vs_out <= vs_p0;
    end
  end

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out: the driver pushes each pixel's expected output
// into a queue. The expectation comes from a frame/line/pixel model. A monitor pops
// and compares one entry each time the DUT advances.
module tb_vga_dither_out;
  localparam int IB = 6;
  localparam int OB = 3;
  localparam int DD = IB - OB;
  localparam logic ACT = 1'b0;

  logic clk_vga = 1'b0;
  logic reset, pix_ce, hs_in, vs_in, hs_out, vs_out;
  logic [1:0] mode;
  logic [IB-1:0] r_in, g_in, b_in;
  logic [OB-1:0] r_out, g_out, b_out;

  vga_dither_out #(.IN_BITS(IB), .OUT_BITS(OB), .SYNC_POL(0)) dut (
    .clk_vga(clk_vga), .reset(reset), .pix_ce(pix_ce), .mode(mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .hs_in(hs_in), .vs_in(vs_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic [OB-1:0] r, g, b;
    logic hs, vs;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, in pixel/line/frame terms.
  int mx, my, mf, mmode;
  logic mprev_hs, mprev_vs;
  int b4[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  int b2[2][2] = '{'{0, 2}, '{3, 1}};

  function automatic int thr(int md, int x, int y, int f, int m4[4][4], int m2[2][2]);
    int mv;
    if (md == 0) return 0;
    if (md == 1) mv = 4 * m2[y % 2][x % 2];
    else if (md == 2) mv = m4[y][x];
    else mv = m4[y][(x + f) % 4];
    if (DD <= 4) return mv / (1 << (4 - DD));
    return mv * (1 << (DD - 4));
  endfunction

  function automatic int chan(int v, int t);
    int q;
    q = (v + t) / (1 << DD);
    return (q > (1 << OB) - 1) ? (1 << OB) - 1 : q;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mf = 0; mmode = 0;
    mprev_hs = ~ACT; mprev_vs = ~ACT;
  endtask

  // One clock of stimulus; accepted pixels update the model and feed the scoreboard.
  task automatic cyc(input logic ce, input logic rst, input logic [1:0] md,
                     input logic [IB-1:0] r, input logic [IB-1:0] g, input logic [IB-1:0] b,
                     input logic hs, input logic vs);
    bit hl, vl;
    int t;
    exp_t e;
    @(negedge clk_vga);
    pix_ce = ce; reset = rst; mode = md;
    r_in = r; g_in = g; b_in = b; hs_in = hs; vs_in = vs;
    if (rst) begin
      model_reset();
    end else if (ce) begin
      hl = (hs == ACT) && (mprev_hs != ACT);
      vl = (vs == ACT) && (mprev_vs != ACT);
      mprev_hs = hs; mprev_vs = vs;
      mx = hl ? 0 : (mx + 1) % 4;
      if (vl) my = 0;
      else if (hl) my = (my + 1) % 4;
      if (vl) begin
        mf = (mf + 1) % 4;
        mmode = int'(md);
      end
      t = thr(mmode, mx, my, mf, b4, b2);
      e.r = OB'(chan(int'(r), t));
      e.g = OB'(chan(int'(g), t));
      e.b = OB'(chan(int'(b), t));
      e.hs = hs; e.vs = vs;
      sb.push_back(e);
    end
  endtask

  // One line: 2-pixel hsync pulse, random idle cycles, constant or random colour.
  task automatic line(input int len, input logic vsl, input int rnd, input int cval,
                      input logic [1:0] md);
    logic [IB-1:0] r, g, b;
    logic hs;
    for (int i = 0; i < len; i++) begin
      hs = (i < 2) ? ACT : ~ACT;
      if (rnd != 0) begin
        r = IB'($urandom); g = IB'($urandom); b = IB'($urandom);
      end else begin
        r = IB'(cval); g = IB'(cval); b = IB'(cval);
      end
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, md, r, g, b, hs, vsl);
      cyc(1'b1, 1'b0, md, r, g, b, hs, vsl);
    end
  endtask

  // One frame: vsync active for the first two lines.
  task automatic frame(input int lines, input int len, input int rnd, input int cval,
                       input logic [1:0] md);
    for (int l = 0; l < lines; l++)
      line(len, (l < 2) ? ACT : ~ACT, rnd, cval, md);
  endtask

  task automatic chk(input string nm, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got r=%0d g=%0d b=%0d hs=%b vs=%b expected r=%0d g=%0d b=%0d hs=%b vs=%b",
               nm, got.r, got.g, got.b, got.hs, got.vs, want.r, want.g, want.b, want.hs, want.vs);
    end
  endtask

  // Monitor: each output advance corresponds to the pixel accepted one pix_ce earlier.
  initial begin
    int n;
    bit have_last;
    logic s_ce, s_rst;
    exp_t last, got, want;
    n = 0; have_last = 0; last = '0;
    forever begin
      @(posedge clk_vga);
      s_ce = pix_ce; s_rst = reset;
      #1;
      got = {r_out, g_out, b_out, hs_out, vs_out};
      if (s_rst === 1'b1) begin
        want = '0; want.hs = ~ACT; want.vs = ~ACT;
        chk("reset_state", got, want);
        n = 0; have_last = 0;
        sb.delete();
      end else if (s_ce === 1'b1) begin
        n++;
        if (n >= 2) begin
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_empty got an output with no expected entry");
          end else begin
            want = sb.pop_front();
            chk("pixel", got, want);
            last = want; have_last = 1;
          end
        end
      end else if (have_last) begin
        chk("hold", got, last);
      end
    end
  end

  initial begin
    logic [1:0] md;
    model_reset();
    reset = 1'b1; pix_ce = 1'b0; mode = 2'd0;
    r_in = '0; g_in = '0; b_in = '0; hs_in = ~ACT; vs_in = ~ACT;
    repeat (3) cyc(1'b0, 1'b1, 2'd0, 6'd0, 6'd0, 6'd0, ~ACT, ~ACT);

    // Truncation of a constant 47 (expected 5).
    frame(6, 8, 0, 47, 2'd0);
    // 4x4 dither of 44, latched at vsync.
    frame(6, 8, 0, 44, 2'd2);
    // Saturation at full scale, then black.
    frame(5, 8, 0, 63, 2'd2);
    frame(5, 8, 0, 0, 2'd2);
    // Temporal rotation over five frames (frame counter wraps).
    for (int f = 0; f < 5; f++) frame(5, 8, 0, 44, 2'd3);
    // 2x2 dither.
    frame(5, 8, 0, 42, 2'd1);
    // Mode changed mid-frame: takes effect only at the next vsync.
    frame(2, 8, 0, 44, 2'd0);
    for (int l = 0; l < 4; l++) line(8, ~ACT, 0, 44, 2'd2);
    frame(5, 8, 0, 44, 2'd2);

    // Reset mid-line with pix_ce toggling, then hs/vs leading edges together.
    line(3, ~ACT, 1, 0, 2'd2);
    cyc(1'b1, 1'b1, 2'd2, 6'd30, 6'd31, 6'd32, ~ACT, ~ACT);
    cyc(1'b0, 1'b1, 2'd2, 6'd30, 6'd31, 6'd32, ~ACT, ~ACT);
    cyc(1'b1, 1'b1, 2'd2, 6'd30, 6'd31, 6'd32, ~ACT, ~ACT);
    line(6, ~ACT, 1, 0, 2'd3);
    frame(5, 8, 1, 0, 2'd3);

    // Reset while syncs are held active: the first pix_ce after release sees an edge.
    cyc(1'b1, 1'b1, 2'd2, 6'd1, 6'd2, 6'd3, ACT, ACT);
    frame(4, 7, 1, 0, 2'd2);

    // Random frames, modes, line lengths and colours.
    for (int f = 0; f < 10; f++) begin
      md = 2'($urandom);
      frame($urandom_range(4, 7), $urandom_range(5, 9), 1, 0, md);
    end

    repeat (4) cyc(1'b0, 1'b0, 2'd0, 6'd0, 6'd0, 6'd0, ~ACT, ~ACT);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
